mmio_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU data-memory path; the slave end of the CPU's load/store I/O accesses.
- Owns the board I/O: synchronises the 16 switches, debounces the button, holds the LED register and counts button presses.
- Answers each CPU access with a one-cycle-latency ready/read-data handshake.
- Applies byte, half and word lane selection and sign/zero extension, using the same length/sign encoding as the data memory.

---
 rtl/mmio_responder.sv | 169 ++++++++++++++++
 tb/tb_mmio_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder: switch/button synchronisers, button debounce and press counter,
// LED register, and a one-cycle-latency ready/rdata/err response to CPU load/store accesses.
module mmio_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_req,
    input  logic        io_we,
    input  logic [7:0]  io_addr,
    input  logic [1:0]  io_length,
    input  logic        io_sign,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        io_ready,
    output logic        io_err,
    input  logic [15:0] switches,
    input  logic        button,
    output logic [15:0] LED
);

    typedef enum logic [1:0] {
        REG_SW  = 2'd0,
        REG_BTN = 2'd1,
        REG_LED = 2'd2,
        REG_CNT = 2'd3
    } reg_sel_e;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      r_sw_s1, r_sw_s2;
    logic             r_btn_s1, r_btn_s2;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_level;
    logic             r_sticky;
    logic [15:0]      r_press_cnt;
    logic [15:0]      r_led;
    logic             r_ready;
    logic             r_err;
    logic [31:0]      r_rdata;

    reg_sel_e    w_sel;
    logic        w_err;
    logic        w_ok;
    logic        w_btn_rd;
    logic        w_differ;
    logic        w_toggle;
    logic        w_press;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [15:0] w_led_next;
    logic        w_unused_wdata;

    assign w_sel = reg_sel_e'(io_addr[3:2]);

    // Any single violation makes the access an error and suppresses all of its side effects.
    assign w_err = (|io_addr[7:4])
                 | (io_length == 2'd3)
                 | ((io_length == 2'd1) && io_addr[0])
                 | ((io_length == 2'd2) && (io_addr[1:0] != 2'd0))
                 | (io_we && (w_sel != REG_LED));
    assign w_ok     = io_req && !w_err;
    assign w_btn_rd = w_ok && !io_we && (w_sel == REG_BTN);

    assign w_differ = r_btn_s2 ^ r_level;
    assign w_toggle = w_differ && (r_db_cnt == LP_LAST);
    assign w_press  = w_toggle && !r_level;

    assign w_unused_wdata = ^io_wdata[31:16];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_word = '0;
        unique case (w_sel)
            REG_SW:  w_word = {16'b0, r_sw_s2};
            REG_BTN: w_word = {30'b0, r_sticky, r_level};
            REG_LED: w_word = {16'b0, r_led};
            REG_CNT: w_word = {16'b0, r_press_cnt};
            default: w_word = '0;
        endcase

        w_byte = '0;
        unique case (io_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = '0;
        endcase

        w_half = io_addr[1] ? w_word[31:16] : w_word[15:0];

        w_load_data = w_word;
        if (io_length == 2'd0)
            w_load_data = {{24{io_sign & w_byte[7]}}, w_byte};
        else if (io_length == 2'd1)
            w_load_data = {{16{io_sign & w_half[15]}}, w_half};
    end

    // Only lanes 0 and 1 exist; writes aimed at lanes 2/3 are silently dropped.
    always_comb begin
        w_led_next = r_led;
        if (w_ok && io_we) begin
            if (io_length == 2'd0) begin
                if (io_addr[1:0] == 2'd0) w_led_next[7:0]  = io_wdata[7:0];
                if (io_addr[1:0] == 2'd1) w_led_next[15:8] = io_wdata[7:0];
            end else if (io_length == 2'd1) begin
                if (!io_addr[1]) w_led_next = io_wdata[15:0];
            end else begin
                w_led_next = io_wdata[15:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_db_cnt    <= '0;
            r_level     <= 1'b0;
            r_sticky    <= 1'b0;
            r_press_cnt <= '0;
            r_led       <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_sw_s1  <= switches;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= button;
            r_btn_s2 <= r_btn_s1;

            if (!w_differ) begin
                r_db_cnt <= '0;
            end else if (w_toggle) begin
                r_db_cnt <= '0;
                r_level  <= ~r_level;
            end else begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end

            // A press on the same edge as a clearing read keeps the flag set.
            if (w_press)
                r_sticky <= 1'b1;
            else if (w_btn_rd)
                r_sticky <= 1'b0;

            if (w_press)
                r_press_cnt <= r_press_cnt + 16'd1;

            r_led   <= w_led_next;
            r_ready <= io_req;
            r_err   <= io_req && w_err;
            r_rdata <= (w_ok && !io_we) ? w_load_data : 32'd0;
        end
    end

    assign io_rdata = r_rdata;
    assign io_ready = r_ready;
    assign io_err   = r_err;
    assign LED      = r_led;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: each issued access queues its expected response,
// a monitor pops and compares whenever io_ready is seen.
module tb_mmio_responder;

    localparam int unsigned DEB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [1:0]  io_length;
    logic        io_sign;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ready;
    logic        io_err;
    logic [15:0] switches;
    logic        button;
    logic [15:0] LED;

    mmio_responder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_length (io_length),
        .io_sign   (io_sign),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .io_ready  (io_ready),
        .io_err    (io_err),
        .switches  (switches),
        .button    (button),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (io_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_rdata"}, io_rdata, e.rdata);
                    check({e.name, "_err"}, {31'b0, io_err}, {31'b0, e.err});
                end
            end else if (io_err) begin
                check("err_without_ready", 32'd1, 32'd0);
            end
        end
    end

    // Called at a negedge; drives one request for the next posedge and returns at the following negedge.
    task automatic issue(input string name, input logic we, input logic [7:0] addr,
                         input logic [1:0] len, input logic sign, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        io_req    = 1'b1;
        io_we     = we;
        io_addr   = addr;
        io_length = len;
        io_sign   = sign;
        io_wdata  = wdata;
        e.name  = name;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(negedge clk);
        io_req = 1'b0;
        io_we  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        io_req    = 1'b0;
        io_we     = 1'b0;
        io_addr   = '0;
        io_length = '0;
        io_sign   = 1'b0;
        io_wdata  = '0;
        switches  = '0;
        button    = 1'b0;
        idle(2);
        check("rst_led",   {16'b0, LED}, 32'd0);
        check("rst_ready", {31'b0, io_ready}, 32'd0);
        check("rst_rdata", io_rdata, 32'd0);
        check("rst_err",   {31'b0, io_err}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Store then load of the LED register.
        issue("st_word_led", 1'b1, 8'h08, 2'd2, 1'b0, 32'h0000A5C3, 32'h0, 1'b0);
        check("led_after_word", {16'b0, LED}, 32'h0000A5C3);
        issue("ld_word_led", 1'b0, 8'h08, 2'd2, 1'b0, 32'h0, 32'h0000A5C3, 1'b0);
        idle(2);

        // Byte/half lanes and extension.
        issue("st_byte_09", 1'b1, 8'h09, 2'd0, 1'b0, 32'h0000007E, 32'h0, 1'b0);
        check("led_after_byte", {16'b0, LED}, 32'h00007EC3);
        issue("ld_byte_s_09", 1'b0, 8'h09, 2'd0, 1'b1, 32'h0, 32'h0000007E, 1'b0);
        issue("st_word_80ff", 1'b1, 8'h08, 2'd2, 1'b0, 32'h000080FF, 32'h0, 1'b0);
        issue("ld_half_s_08", 1'b0, 8'h08, 2'd1, 1'b1, 32'h0, 32'hFFFF80FF, 1'b0);
        issue("ld_half_u_08", 1'b0, 8'h08, 2'd1, 1'b0, 32'h0, 32'h000080FF, 1'b0);
        issue("ld_byte_s_08", 1'b0, 8'h08, 2'd0, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0);
        issue("ld_byte_u_08", 1'b0, 8'h08, 2'd0, 1'b0, 32'h0, 32'h000000FF, 1'b0);
        issue("ld_byte_0a",   1'b0, 8'h0A, 2'd0, 1'b1, 32'h0, 32'h00000000, 1'b0);
        issue("st_byte_0b",   1'b1, 8'h0B, 2'd0, 1'b0, 32'h00000055, 32'h0, 1'b0);
        issue("st_half_0a",   1'b1, 8'h0A, 2'd1, 1'b0, 32'h00001234, 32'h0, 1'b0);
        check("led_upper_lanes_ignored", {16'b0, LED}, 32'h000080FF);
        issue("ld_half_0a",   1'b0, 8'h0A, 2'd1, 1'b1, 32'h0, 32'h00000000, 1'b0);

        // Switch synchroniser.
        switches = 16'h9234;
        idle(3);
        issue("ld_sw_word",   1'b0, 8'h00, 2'd2, 1'b0, 32'h0, 32'h00009234, 1'b0);
        issue("ld_sw_half_s", 1'b0, 8'h00, 2'd1, 1'b1, 32'h0, 32'hFFFF9234, 1'b0);
        issue("ld_sw_byte1",  1'b0, 8'h01, 2'd0, 1'b0, 32'h0, 32'h00000092, 1'b0);
        issue("ld_cnt_init",  1'b0, 8'h0C, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0);

        // Error cases, none of which may touch state.
        issue("err_st_sw",     1'b1, 8'h00, 2'd2, 1'b0, 32'h0000FFFF, 32'h0, 1'b1);
        issue("err_ld_mis_0a", 1'b0, 8'h0A, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
        issue("err_ld_unmap",  1'b0, 8'h20, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
        issue("err_len3",      1'b0, 8'h08, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        issue("err_st_mis_09", 1'b1, 8'h09, 2'd1, 1'b0, 32'h00000000, 32'h0, 1'b1);
        issue("err_st_len3",   1'b1, 8'h08, 2'd3, 1'b0, 32'h00000000, 32'h0, 1'b1);
        idle(2);
        check("led_after_errors", {16'b0, LED}, 32'h000080FF);

        // Debounce: a 5-cycle glitch must not register.
        button = 1'b1;
        idle(5);
        button = 1'b0;
        idle(20);
        issue("ld_btn_after_glitch", 1'b0, 8'h04, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);

        // Stable high: level rises on edge 2+8; a BTN load on that edge sees the old value and sticky survives.
        button = 1'b1;
        idle(DEB);
        issue("ld_btn_edge9",  1'b0, 8'h04, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
        issue("ld_btn_edge10", 1'b0, 8'h04, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        issue("err_st_btn",    1'b1, 8'h04, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
        issue("err_ld_btn_mis", 1'b0, 8'h05, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
        button = 1'b0;
        idle(20);
        issue("ld_btn_sticky",  1'b0, 8'h04, 2'd2, 1'b0, 32'h0, 32'h00000002, 1'b0);
        issue("ld_btn_cleared", 1'b0, 8'h04, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0);
        issue("ld_cnt_one",     1'b0, 8'h0C, 2'd2, 1'b0, 32'h0, 32'h00000001, 1'b0);

        // Press counter wrap from a preset 0xFFFF.
        force dut.r_press_cnt = 16'hFFFF;
        idle(1);
        release dut.r_press_cnt;
        issue("ld_cnt_preset", 1'b0, 8'h0C, 2'd2, 1'b0, 32'h0, 32'h0000FFFF, 1'b0);
        button = 1'b1;
        idle(15);
        issue("ld_cnt_wrap",  1'b0, 8'h0C, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0);
        issue("ld_btn_press", 1'b0, 8'h04, 2'd2, 1'b0, 32'h0, 32'h00000003, 1'b0);
        button = 1'b0;
        idle(20);
        drain();

        // Reset lands while a load is pending: no response may follow.
        io_req    = 1'b1;
        io_we     = 1'b0;
        io_addr   = 8'h08;
        io_length = 2'd2;
        #2 rst_n  = 1'b0;
        @(negedge clk);
        io_req = 1'b0;
        check("rst_mid_ready", {31'b0, io_ready}, 32'd0);
        check("rst_mid_led",   {16'b0, LED}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        check("rst_mid_ready_after", {31'b0, io_ready}, 32'd0);
        idle(2);
        issue("ld_cnt_after_rst", 1'b0, 8'h0C, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0);
        idle(2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
